// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-64 logic path: operation codes and the
// state encoding of the sliced logic sequencer.
package alu_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/and_wordgate.sv
// Plain w-bit bitwise AND gate; the only gate logic in the logic slice path.
module and_wordgate #(
    parameter int w = 16
) (
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    output logic [w-1:0] y
);

    assign y = a & b;

endmodule

// File: rtl/logic_slice_seq.sv
// Multi-cycle 64-bit AND/NAND/OR/NOR built from one narrow AND slice,
// processed least-significant slice first, valid/ready on both sides.
module logic_slice_seq
    import alu_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    localparam int NSLICES = DATA_W / SLICE_W;
    localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICES - 1);

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [1:0]          op_reg;
    logic [DATA_W-1:0]   result_reg;
    logic                zero_reg;
    logic                out_valid_reg;

    logic [SLICE_W-1:0]  a_sl [NSLICES];
    logic [SLICE_W-1:0]  b_sl [NSLICES];
    logic [SLICE_W-1:0]  a_slice;
    logic [SLICE_W-1:0]  b_slice;
    logic [SLICE_W-1:0]  gate_a;
    logic [SLICE_W-1:0]  gate_b;
    logic [SLICE_W-1:0]  gate_y;
    logic [SLICE_W-1:0]  slice_out;
    logic [DATA_W-1:0]   result_next;
    logic                inv_in;
    logic                inv_out;

    // Split latched operands into slices and merge the current slice output
    // into the result word; only the slice addressed by cnt_reg changes.
    for (genvar gi = 0; gi < NSLICES; gi++) begin : g_slice
        assign a_sl[gi] = a_reg[gi*SLICE_W +: SLICE_W];
        assign b_sl[gi] = b_reg[gi*SLICE_W +: SLICE_W];
        assign result_next[gi*SLICE_W +: SLICE_W] =
            (cnt_reg == CNT_W'(gi)) ? slice_out : result_reg[gi*SLICE_W +: SLICE_W];
    end

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NSLICES; i++) begin
            if (cnt_reg == CNT_W'(i)) begin
                a_slice = a_sl[i];
                b_slice = b_sl[i];
            end
        end
    end

    // De Morgan: OR/NOR invert the inputs, NAND/OR invert the output.
    assign inv_in  = (op_reg == OP_OR)   || (op_reg == OP_NOR);
    assign inv_out = (op_reg == OP_NAND) || (op_reg == OP_OR);

    assign gate_a    = inv_in  ? ~a_slice : a_slice;
    assign gate_b    = inv_in  ? ~b_slice : b_slice;
    assign slice_out = inv_out ? ~gate_y  : gate_y;

    and_wordgate #(
        .w (SLICE_W)
    ) u_gate (
        .a (gate_a),
        .b (gate_b),
        .y (gate_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= OP_AND;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        op_reg     <= op;
                        result_reg <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_reg <= result_next;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg       <= '0;
                        state_reg     <= S_DONE;
                        out_valid_reg <= 1'b1;
                        zero_reg      <= (result_next == '0);
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_reg     <= S_IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_logic_slice_seq.sv
// Randomised self-checking bench for logic_slice_seq against a cycle-level
// behavioural model, plus directed cases and a single-slice instance.
module tb_logic_slice_seq;
    import alu_pkg::*;

    localparam int DW = 64;
    localparam int SW = 16;
    localparam int NS = DW / SW;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] result;
    logic        zero;

    logic        in_valid1 = 1'b0;
    logic        out_ready1 = 1'b0;
    logic [1:0]  op1 = 2'b00;
    logic [63:0] a1 = '0;
    logic [63:0] b1 = '0;
    logic        in_ready1;
    logic        out_valid1;
    logic [63:0] result1;
    logic        zero1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_slice_seq #(.DATA_W(DW), .SLICE_W(SW)) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    logic_slice_seq #(.DATA_W(64), .SLICE_W(64)) dut1 (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid1), .in_ready(in_ready1),
        .op(op1), .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .zero(zero1)
    );

    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [63:0] x,
                                           input logic [63:0] y);
        case (o)
            OP_AND:  return x & y;
            OP_NAND: return ~(x & y);
            OP_OR:   return x | y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation takes NS edges, slice k of the final
    // value becomes visible after k+1 of them; then it waits for out_ready.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_final = '0;
    logic [63:0] m_res = '0;
    bit          m_zero = 1'b0;
    bit          chk_en = 1'b0;
    int          written;

    always @(posedge clk) begin
        if (!rst_b) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
            m_zero = 1'b0;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            written = NS - m_left;
            m_res = (written == NS) ? m_final
                                    : (m_final & ((64'd1 << (written * SW)) - 64'd1));
            if (m_left == 0) begin
                m_done = 1'b1;
                m_zero = (m_final == '0);
            end
        end else if (in_valid) begin
            m_final = ref_op(op, a, b);
            m_left  = NS;
            m_res   = '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, (!m_done && m_left == 0));
            check("out_valid", out_valid, m_done);
            check("result", result, m_res);
            if (m_done) check("zero", zero, m_zero);
        end
    end

    // Called at a negedge; leaves at a negedge with the block back in IDLE.
    task automatic run_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                          input int hold, input bit lit_chk, input logic [63:0] lit);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0");
            return;
        end
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        op = 2'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        check("latency", n, NS);
        check("result_ref", result, ref_op(o, x, y));
        check("zero_ref", zero, (ref_op(o, x, y) == '0));
        if (lit_chk) begin
            check("result_lit", result, lit);
            check("model_lit", m_res, lit);
        end
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        check("ready_after_done", in_ready, 1'b1);
        check("valid_after_done", out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    localparam logic [63:0] TA = 64'hFFFF_0000_F0F0_1234;
    localparam logic [63:0] TB = 64'h0F0F_FFFF_FF00_00FF;

    initial begin
        int n;
        logic [63:0] x2, y2;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        chk_en = 1'b1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 64'h0);
        check("rst_zero", zero, 1'b0);
        check("rst1_in_ready", in_ready1, 1'b1);

        run_op(OP_AND, TA, TB, 0, 1'b1, 64'h0F0F_0000_F000_0034);
        run_op(OP_OR,  TA, TB, 0, 1'b1, 64'hFFFF_FFFF_FFF0_12FF);
        run_op(OP_NOR, TA, TB, 1, 1'b1, 64'h0000_0000_000F_ED00);
        run_op(OP_NAND, '1, '1, 0, 1'b1, 64'h0);
        check("nand_zero", zero, 1'b1);
        run_op(OP_AND, '0, '1, 2, 1'b1, 64'h0);

        // Backpressure with a competing request held during DONE.
        x2 = 64'h1234_5678_9ABC_DEF0;
        y2 = 64'h0F0F_0F0F_0000_FFFF;
        op = OP_AND; a = TA; b = TB; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op = OP_OR; a = x2; b = y2;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        repeat (5) begin
            check("bp_result", result, 64'h0F0F_0000_F000_0034);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1'b1);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        check("bp_new_latency", n, NS);
        check("bp_new_result", result, ref_op(OP_OR, x2, y2));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset after two slices have been written.
        op = OP_NOR; a = TA; b = TB; in_valid = 1'b1;
        @(posedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_result", result, 64'h0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        run_op(OP_AND, TA, TB, 0, 1'b1, 64'h0F0F_0000_F000_0034);

        // Randomised traffic.
        repeat (150) begin
            logic [63:0] rx, ry;
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) ry = ~rx;
            run_op(2'($urandom), rx, ry, $urandom_range(0, 3), 1'b0, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Single-slice instance.
        op1 = OP_AND; a1 = 64'h8000_0000_0000_0001; b1 = '1;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        a1 = '0;
        check("s1_run_ready", in_ready1, 1'b0);
        check("s1_run_valid", out_valid1, 1'b0);
        @(negedge clk);
        check("s1_valid", out_valid1, 1'b1);
        check("s1_result", result1, 64'h8000_0000_0000_0001);
        check("s1_zero", zero1, 1'b0);
        @(negedge clk);
        check("s1_idle_valid", out_valid1, 1'b0);
        check("s1_idle_ready", in_ready1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logic_slice_seq.md
Name: logic_slice_seq

Overview:
- Multi-cycle sequencer that computes 64-bit bitwise logic results using one narrow and_wordgate slice.
- Each operation is processed in SLICE_W-bit chunks, least-significant slice first.
- AND, NAND, OR and NOR are all built from the single AND gate: OR and NOR by inverting the inputs (De Morgan), NAND and OR by inverting the output.
- Sits in the ALU-64 logic path. Uses a valid/ready handshake on operand input and on result output.

Parameters:
- DATA_W, 64, operand/result width; must be an integer multiple of SLICE_W.
- SLICE_W, 16, width of the shared and_wordgate instance (w = SLICE_W).
- NSLICES, DATA_W/SLICE_W, localparam; number of RUN cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_b  input  1  synchronous active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation.
- op  input  2  operation: 00 AND, 01 NAND, 10 OR, 11 NOR.
- a  input  DATA_W  operand A.
- b  input  DATA_W  operand B.
- out_valid  output  1  result is valid and held.
- out_ready  input  1  consumer accepts the result.
- result  output  DATA_W  registered result.
- zero  output  1  result == 0; valid while out_valid is high.

Behaviour:
- Reset: rst_b low at a rising edge sends the block to IDLE, whatever state it was in (including mid-RUN). After that edge:
  - state = IDLE, slice counter = 0.
  - result = 0, zero = 0, out_valid = 0.
  - in_ready = 1 (in_ready = state==IDLE, combinational).
  - The partially computed operation is discarded.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: latch a, b and op; clear result to 0; set cnt = 0; go to RUN.
  - out_ready is ignored.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Every edge: result[cnt*SLICE_W +: SLICE_W] <= slice output, then cnt++.
  - Slice input = latched a/b slice, bitwise-inverted when op is OR or NOR.
  - Slice output = AND result, inverted when op is NAND or OR.
  - The edge that writes slice NSLICES-1 also moves to DONE, sets out_valid = 1 and registers zero from the complete result.
- DONE:
  - result and zero are held stable.
  - On an edge with out_ready = 1: go to IDLE, clear out_valid. result keeps its value until the next accept.
- Latency: out_valid goes high exactly NSLICES cycles after the accept edge. With the defaults that is 4 cycles.
- Throughput: at most one operation per NSLICES + 2 cycles. There is no overlap: in_ready is low through RUN and DONE.
- NSLICES = 1: RUN lasts exactly one cycle.
- Operand isolation: a, b and op may change after acceptance with no effect on the operation in flight.
- Counter width is clog2(NSLICES), with a minimum of 1 bit. cnt never exceeds NSLICES-1.
- Reset dominates all other inputs on the same edge.

Decomposition:
- Shared package/header alu_pkg holds:
  - op codes OP_AND = 2'b00, OP_NAND = 2'b01, OP_OR = 2'b10, OP_NOR = 2'b11;
  - state encodings S_IDLE, S_RUN, S_DONE.
- Sub-module: one instance of the existing and_wordgate with w = SLICE_W. It is the only gate logic; the inversions sit around it in this block.

Test Plan (DATA_W = 64, SLICE_W = 16 unless stated):
- AND: a = 64'hFFFF_0000_F0F0_1234, b = 64'h0F0F_FFFF_FF00_00FF, out_ready = 1 -> result = 64'h0F0F_0000_F000_0034, zero = 0, out_valid high 4 cycles after accept for 1 cycle, in_ready back to 1 on the following cycle.
- OR then NOR, same operands -> OR result = 64'hFFFF_FFFF_FFF0_12FF; NOR result = 64'h0000_0000_000F_ED00.
- NAND with a = b = 64'hFFFF_FFFF_FFFF_FFFF -> result = 0, zero = 1. AND with a = 0, b = all ones -> zero = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while driving in_valid with new operands -> result and out_valid stay stable, in_ready = 0, the new op is not taken. Raise out_ready -> IDLE, then the new op is accepted and computed correctly.
- Reset mid-RUN: drop rst_b for one edge after 2 slices are written -> out_valid = 0, result = 0, in_ready = 1. A subsequent AND completes with the correct value and 4-cycle latency.
- Instance with SLICE_W = 64 (NSLICES = 1): AND of 64'h8000_0000_0000_0001 and 64'hFFFF_FFFF_FFFF_FFFF -> result = 64'h8000_0000_0000_0001, out_valid 1 cycle after accept.
